// File: rtl/argmax_layer_if.sv
// Score-vector in / classification-result out bundle for argmax_layer.
// Master drives the vector and consumes the result; slave is the classifier.
interface argmax_layer_if #(
  parameter int WORD_SIZE  = 16,
  parameter int INPUT_SIZE = 10
);
  localparam int INDEX_BITS = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  logic                            valid_i;
  logic                            ready_o;
  logic [INPUT_SIZE*WORD_SIZE-1:0] data_i;
  logic                            mode_i;
  logic                            valid_o;
  logic                            yumi_i;
  logic [INDEX_BITS-1:0]           class_o;
  logic [WORD_SIZE-1:0]            score_o;
  logic [WORD_SIZE-1:0]            margin_o;

  modport master (
    output valid_i, data_i, mode_i, yumi_i,
    input  ready_o, valid_o, class_o, score_o, margin_o
  );

  modport slave (
    input  valid_i, data_i, mode_i, yumi_i,
    output ready_o, valid_o, class_o, score_o, margin_o
  );
endinterface

// File: rtl/argmax_layer.sv
// Sequential argmax/argmin over a score vector, LANES candidates per cycle; result after 1+ceil((N-1)/LANES) cycles.
// Accepts only in IDLE (ready_o); result held with valid_o until yumi_i, then returns to IDLE.
module argmax_layer #(
  parameter int WORD_SIZE  = 16,
  parameter int INPUT_SIZE = 10,
  parameter int LANES      = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  argmax_layer_if.slave  io
);
  localparam int INDEX_BITS = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int PTR_BITS   = $clog2(INPUT_SIZE + LANES + 1);
  localparam logic signed [WORD_SIZE-1:0] MAX_V = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] MIN_V = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                        state;
  logic signed [WORD_SIZE-1:0]   elems [INPUT_SIZE];
  logic                          mode_r;
  logic signed [WORD_SIZE-1:0]   best;
  logic signed [WORD_SIZE-1:0]   second;
  logic [INDEX_BITS-1:0]         best_idx;
  logic [PTR_BITS-1:0]           ptr;
  logic                          ready_r;
  logic                          valid_r;
  logic [INDEX_BITS-1:0]         class_r;
  logic [WORD_SIZE-1:0]          score_r;
  logic [WORD_SIZE-1:0]          margin_r;

  logic signed [WORD_SIZE-1:0]   nb;
  logic signed [WORD_SIZE-1:0]   ns;
  logic [INDEX_BITS-1:0]         ni;
  logic signed [WORD_SIZE-1:0]   cand;
  logic [PTR_BITS-1:0]           cand_idx;
  logic [PTR_BITS-1:0]           ptr_next;
  logic [WORD_SIZE:0]            diff;
  logic [WORD_SIZE-1:0]          margin_n;

  function automatic logic better(input logic signed [WORD_SIZE-1:0] a,
                                  input logic signed [WORD_SIZE-1:0] b,
                                  input logic mn);
    return mn ? (a < b) : (a > b);
  endfunction

  // Lanes are chained in ascending index order so strict compares keep the lowest index on ties.
  always_comb begin
    nb       = best;
    ns       = second;
    ni       = best_idx;
    cand     = '0;
    cand_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      cand_idx = ptr + PTR_BITS'(l);
      if (cand_idx < PTR_BITS'(INPUT_SIZE)) begin
        cand = elems[cand_idx[INDEX_BITS-1:0]];
        if (better(cand, nb, mode_r)) begin
          ns = nb;
          nb = cand;
          ni = cand_idx[INDEX_BITS-1:0];
        end else if (better(cand, ns, mode_r)) begin
          ns = cand;
        end
      end
    end
  end

  assign ptr_next = ptr + PTR_BITS'(LANES);

  // Difference is never negative; anything past the signed maximum clamps.
  always_comb begin
    diff = mode_r ? ({second[WORD_SIZE-1], second} - {best[WORD_SIZE-1], best})
                  : ({best[WORD_SIZE-1], best} - {second[WORD_SIZE-1], second});
    if (INPUT_SIZE == 1)
      margin_n = '0;
    else if (diff[WORD_SIZE] || diff[WORD_SIZE-1])
      margin_n = MAX_V;
    else
      margin_n = diff[WORD_SIZE-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      for (int k = 0; k < INPUT_SIZE; k++) elems[k] <= '0;
      mode_r   <= 1'b0;
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
      ptr      <= '0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      class_r  <= '0;
      score_r  <= '0;
      margin_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.valid_i) begin
            for (int k = 0; k < INPUT_SIZE; k++)
              elems[k] <= io.data_i[k*WORD_SIZE +: WORD_SIZE];
            mode_r   <= io.mode_i;
            best     <= io.data_i[WORD_SIZE-1:0];
            best_idx <= '0;
            second   <= io.mode_i ? MAX_V : MIN_V;
            ptr      <= PTR_BITS'(1);
            ready_r  <= 1'b0;
            state    <= (INPUT_SIZE == 1) ? DONE : SCAN;
          end
        end
        SCAN: begin
          best     <= nb;
          second   <= ns;
          best_idx <= ni;
          ptr      <= ptr_next;
          if (ptr_next >= PTR_BITS'(INPUT_SIZE))
            state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; later cycles hold it until taken.
          if (!valid_r) begin
            class_r  <= best_idx;
            score_r  <= best;
            margin_r <= margin_n;
            valid_r  <= 1'b1;
          end else if (io.yumi_i) begin
            class_r  <= '0;
            score_r  <= '0;
            margin_r <= '0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.ready_o  = ready_r;
  assign io.valid_o  = valid_r;
  assign io.class_o  = class_r;
  assign io.score_o  = score_r;
  assign io.margin_o = margin_r;
endmodule

// File: tb/tb_argmax_layer.sv
// Directed, table-driven bench for argmax_layer across four parameter sets.
module tb_argmax_layer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  argmax_layer_if #(.WORD_SIZE(16), .INPUT_SIZE(10)) ia ();
  argmax_layer_if #(.WORD_SIZE(16), .INPUT_SIZE(2))  ib ();
  argmax_layer_if #(.WORD_SIZE(16), .INPUT_SIZE(10)) ic ();
  argmax_layer_if #(.WORD_SIZE(16), .INPUT_SIZE(1))  id ();

  argmax_layer #(.WORD_SIZE(16), .INPUT_SIZE(10), .LANES(1)) dut_a (.clk_i(clk), .reset_i(rst), .io(ia));
  argmax_layer #(.WORD_SIZE(16), .INPUT_SIZE(2),  .LANES(1)) dut_b (.clk_i(clk), .reset_i(rst), .io(ib));
  argmax_layer #(.WORD_SIZE(16), .INPUT_SIZE(10), .LANES(4)) dut_c (.clk_i(clk), .reset_i(rst), .io(ic));
  argmax_layer #(.WORD_SIZE(16), .INPUT_SIZE(1),  .LANES(1)) dut_d (.clk_i(clk), .reset_i(rst), .io(id));

  typedef struct {
    logic [159:0] data;
    logic         mode;
    int           cls;
    int           score;
    int           margin;
    int           hold;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [159:0] pk(input int e0, input int e1, input int e2, input int e3,
                                      input int e4, input int e5, input int e6, input int e7,
                                      input int e8, input int e9);
    int e [10];
    logic [159:0] r;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8, e9};
    r = '0;
    for (int k = 0; k < 10; k++) r[k*16 +: 16] = e[k][15:0];
    return r;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic get_vld(input int w);
    case (w)
      0: return ia.valid_o;
      1: return ib.valid_o;
      2: return ic.valid_o;
      default: return id.valid_o;
    endcase
  endfunction

  function automatic logic get_rdy(input int w);
    case (w)
      0: return ia.ready_o;
      1: return ib.ready_o;
      2: return ic.ready_o;
      default: return id.ready_o;
    endcase
  endfunction

  function automatic int get_cls(input int w);
    case (w)
      0: return int'(ia.class_o);
      1: return int'(ib.class_o);
      2: return int'(ic.class_o);
      default: return int'(id.class_o);
    endcase
  endfunction

  function automatic int get_score(input int w);
    case (w)
      0: return int'($signed(ia.score_o));
      1: return int'($signed(ib.score_o));
      2: return int'($signed(ic.score_o));
      default: return int'($signed(id.score_o));
    endcase
  endfunction

  function automatic int get_margin(input int w);
    case (w)
      0: return int'(ia.margin_o);
      1: return int'(ib.margin_o);
      2: return int'(ic.margin_o);
      default: return int'(id.margin_o);
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [159:0] d, input logic m);
    case (w)
      0: begin ia.valid_i = v; ia.data_i = d;         ia.mode_i = m; end
      1: begin ib.valid_i = v; ib.data_i = d[31:0];   ib.mode_i = m; end
      2: begin ic.valid_i = v; ic.data_i = d;         ic.mode_i = m; end
      default: begin id.valid_i = v; id.data_i = d[15:0]; id.mode_i = m; end
    endcase
  endtask

  task automatic set_yumi(input int w, input logic y);
    case (w)
      0: ia.yumi_i = y;
      1: ib.yumi_i = y;
      2: ic.yumi_i = y;
      default: id.yumi_i = y;
    endcase
  endtask

  // Called at a negedge; counts rising edges until valid_o is seen, bounded.
  task automatic wait_vld(input int w, output int lat);
    lat = 0;
    while (!get_vld(w) && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_res(input int w, input string nm, input int cls, input int sc, input int mg);
    check({nm, " class"},  get_cls(w),    cls);
    check({nm, " score"},  get_score(w),  sc);
    check({nm, " margin"}, get_margin(w), mg);
  endtask

  task automatic take(input int w, input string nm);
    set_yumi(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_yumi(w, 1'b0);
    check({nm, " valid after yumi"}, get_vld(w), 0);
    check({nm, " ready after yumi"}, get_rdy(w), 1);
  endtask

  task automatic run(input int w, input string nm, input logic [159:0] d, input logic m,
                     input int lat_exp, input int cls, input int sc, input int mg, input int hold);
    int lat;
    @(negedge clk);
    check({nm, " ready idle"}, get_rdy(w), 1);
    drive(w, 1'b1, d, m);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, {5{$urandom()}}, 1'($urandom()));
    check({nm, " ready busy"}, get_rdy(w), 0);
    wait_vld(w, lat);
    check({nm, " latency"}, lat, lat_exp);
    check_res(w, nm, cls, sc, mg);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({nm, " valid held"}, get_vld(w), 1);
      check_res(w, {nm, " held"}, cls, sc, mg);
    end
    take(w, nm);
  endtask

  initial begin
    int lat;
    int bad_rdy;
    logic [159:0] va;
    logic [159:0] vb;

    tbl[0] = '{pk(0, 100, 200, 300, 400, 500, 600, 700, 800, 900), 1'b0, 9, 900, 100, 5};
    tbl[1] = '{pk(-5, 7, -3, 7, 0, -20, -20, -20, -20, -20), 1'b0, 1, 7, 0, 0};
    tbl[2] = '{pk(-5, 7, -3, 7, 0, -20, -20, -20, -20, -20), 1'b1, 5, -20, 0, 0};
    tbl[3] = '{pk(50, 40, 30, 20, 10, 0, -10, -20, -30, -40), 1'b1, 9, -40, 10, 0};
    tbl[4] = '{pk(-100, -100, -100, -100, -100, -100, -100, -100, -100, -100), 1'b0, 0, -100, 0, 0};
    tbl[5] = '{pk(-32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1, 32767, 32767, 0};
    tbl[6] = '{pk(-32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 0, -32768, 32767, 0};

    for (int w = 0; w < 4; w++) begin
      drive(w, 1'b0, '0, 1'b0);
      set_yumi(w, 1'b0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset ready", get_rdy(0), 1);
    check("reset valid", get_vld(0), 0);
    check_res(0, "reset", 0, 0, 0);
    for (int w = 1; w < 4; w++) begin
      check($sformatf("reset ready dut%0d", w), get_rdy(w), 1);
      check($sformatf("reset valid dut%0d", w), get_vld(w), 0);
    end

    // yumi_i with nothing pending must not disturb anything
    set_yumi(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_yumi(0, 1'b0);
    check("stray yumi valid", get_vld(0), 0);
    check("stray yumi ready", get_rdy(0), 1);

    for (int i = 0; i < 7; i++)
      run(0, $sformatf("vec%0d", i), tbl[i].data, tbl[i].mode, 10,
          tbl[i].cls, tbl[i].score, tbl[i].margin, tbl[i].hold);

    // Reset two cycles into SCAN abandons the transaction
    @(negedge clk);
    drive(0, 1'b1, tbl[0].data, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset valid", get_vld(0), 0);
    check("midreset ready", get_rdy(0), 1);
    check_res(0, "midreset", 0, 0, 0);
    repeat (12) @(negedge clk);
    check("midreset no result", get_vld(0), 0);
    run(0, "postreset", tbl[3].data, 1'b1, 10, 9, -40, 10, 0);

    // Back-to-back with valid_i held high
    va = tbl[0].data;
    vb = tbl[3].data;
    bad_rdy = 0;
    @(negedge clk);
    drive(0, 1'b1, va, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, vb, 1'b1);
    lat = 0;
    while (!get_vld(0) && lat < 60) begin
      if (get_rdy(0)) bad_rdy++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("b2b A latency", lat, 10);
    check_res(0, "b2b A", 9, 900, 100);
    repeat (2) begin
      if (get_rdy(0)) bad_rdy++;
      @(negedge clk);
    end
    check("b2b ready low in scan/done", bad_rdy, 0);
    set_yumi(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_yumi(0, 1'b0);
    check("b2b no accept on yumi edge", get_rdy(0), 1);
    check("b2b valid dropped", get_vld(0), 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    check("b2b B accepted", get_rdy(0), 0);
    wait_vld(0, lat);
    check("b2b B latency", lat, 10);
    check_res(0, "b2b B", 9, -40, 10);
    take(0, "b2b B");

    // Two-element saturation cases
    run(1, "sat max", pk(32767, -32768, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 2, 0, 32767, 32767, 0);
    run(1, "sat min", pk(32767, -32768, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 2, 1, -32768, 32767, 0);

    // Four lanes per cycle
    run(2, "lanes max", pk(1, 5, -3, 10, 0, 20, 42, -7, 8, 40), 1'b0, 4, 6, 42, 2, 2);
    run(2, "lanes min", pk(1, 5, -3, 10, 0, 20, 42, -7, 8, 40), 1'b1, 4, 7, -7, 4, 0);
    run(2, "lanes tie", pk(3, 9, 9, 1, 9, 0, 0, 0, 0, 2), 1'b0, 4, 1, 9, 0, 0);

    // Single-element vector
    run(3, "single", pk(-10, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1, 0, -10, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
